// File: rtl/vid_linefill.sv
// Palette-based line filler: pulls packed pixel words from a DMA reader, expands them
// through a 256-entry palette and writes them into a line-memory ring. Optional line
// doubling is built when VID_LINEFILL_LINEDOUBLE_EN is defined.
module vid_linefill #(
  parameter int WIDTH     = 480,
  parameter int HEIGHT    = 320,
  parameter int LINE_BITS = 9,
  parameter int BUF_LOG2  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [24:0] addr,
  input  logic [31:0] din,
  input  logic        wen,
  input  logic        ren,
  output logic [31:0] dout,
  output logic        ready,
  output logic [19:0] vid_addr,
  output logic [23:0] vid_data_out,
  output logic        vid_wen,
  input  logic [19:0] curr_vid_addr,
  input  logic        next_field,
  output logic [23:0] dma_start_addr,
  output logic [23:0] dma_end_addr,
  output logic        dma_run,
  output logic        dma_do_read,
  input  logic        dma_ready,
  input  logic [31:0] dma_data
);
  localparam int LB = 20 - LINE_BITS;

  logic [23:0] palette [256];
  logic [23:0] fb_addr, base;
  logic [16:0] pitch, act_pitch;
  logic [2:0]  mode, act_mode;
  logic [LB-1:0]        line;
  logic [LINE_BITS-1:0] pix;
  logic ready_read, ready_write, bubble, gap;

  logic [9:0]  w;
  logic        wsel, fillable, emit, word_last, line_last, adv;
  logic [1:0]  bsel;
  logic [4:0]  bit_off;
  logic [5:0]  bpp;
  logic [7:0]  sh, idx;
  logic [31:0] rdata;

  assign w     = addr[11:2];
  assign wsel  = wen && (addr[23:20] == 4'd0);
  assign ready = (wen & ready_write) | (ren & ready_read);

  assign bsel      = act_mode[1:0];
  assign bpp       = 6'd1 << bsel;
  assign bit_off   = pix[4:0] << bsel;
  assign sh        = 8'(dma_data >> bit_off);
  assign word_last = ({1'b0, bit_off} + bpp) == 6'd32;
  assign line_last = pix == LINE_BITS'(WIDTH - 1);

  always_comb begin
    idx = 8'd0;
    case (bsel)
      2'd0: idx = {7'd0, sh[0]};
      2'd1: idx = {6'd0, sh[1:0]};
      2'd2: idx = {4'd0, sh[3:0]};
      default: idx = sh;
    endcase
  end

  // A slot may be overwritten only while scanout is reading a different slot.
  assign fillable = (line < LB'(HEIGHT)) &&
                    (line[BUF_LOG2-1:0] != curr_vid_addr[LINE_BITS +: BUF_LOG2]);
  assign dma_run        = fillable & ~gap;
  assign emit           = dma_run & dma_ready & ~bubble & ~next_field;
  assign dma_do_read    = emit & word_last;
  assign dma_start_addr = base;
  assign dma_end_addr   = base + (24'(WIDTH / 8) << bsel);

`ifdef VID_LINEFILL_LINEDOUBLE_EN
  // Doubled output: hold the source line for even output lines.
  assign adv = ~act_mode[2] | line[0];
`else
  assign adv = 1'b1;
`endif

  always_comb begin
    rdata = 32'd0;
    case (w)
      10'd256: rdata = {8'd0, fb_addr};
      10'd257: rdata = {15'd0, pitch};
      10'd258: rdata = {29'd0, mode};
      10'd259: rdata = {8'd0, curr_vid_addr, 4'd0};
      default: rdata = 32'd0;
    endcase
  end

  always_ff @(posedge clk)
    if (wsel && w[9:8] == 2'd0) palette[w[7:0]] <= din[23:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      dout         <= '0;
      ready_read   <= 1'b0;
      ready_write  <= 1'b0;
      vid_wen      <= 1'b0;
      vid_addr     <= '0;
      vid_data_out <= '0;
      fb_addr      <= 24'h7E0000;
      pitch        <= 17'(WIDTH / 2);
      mode         <= 3'd2;
      act_pitch    <= 17'(WIDTH / 2);
      act_mode     <= 3'd2;
      base         <= '0;
      line         <= LB'(HEIGHT);
      pix          <= '0;
      bubble       <= 1'b0;
      gap          <= 1'b0;
    end else begin
      ready_write <= wen;
      ready_read  <= ren;
      if (ren) dout <= rdata;
      if (wsel) begin
        case (w)
          10'd256: fb_addr <= din[23:0];
          10'd257: pitch   <= din[16:0];
          10'd258: mode    <= din[2:0];
          default: ;
        endcase
      end
      vid_addr <= {line, pix};
      vid_wen  <= emit;
      bubble   <= emit & word_last;
      gap      <= 1'b0;
      if (emit) vid_data_out <= palette[idx];
      if (next_field) begin
        line      <= '0;
        pix       <= '0;
        base      <= fb_addr;
        act_pitch <= pitch;
        act_mode  <= mode;
      end else if (emit) begin
        if (line_last) begin
          pix  <= '0;
          line <= line + 1'b1;
          gap  <= 1'b1;
          if (adv) base <= base + 24'(act_pitch);
        end else begin
          pix <= pix + 1'b1;
        end
      end
    end
  end

  logic unused_ok;
`ifdef VID_LINEFILL_LINEDOUBLE_EN
  assign unused_ok = &{1'b0, addr[24], addr[19:12], addr[1:0], din[31:24]};
`else
  assign unused_ok = &{1'b0, addr[24], addr[19:12], addr[1:0], din[31:24], act_mode[2]};
`endif
endmodule

// File: tb/tb_vid_linefill.sv
// Directed bench for vid_linefill: table of pixel-decode vectors plus hand-written
// field, mid-field and reset sequences. Honours VID_LINEFILL_LINEDOUBLE_EN.
module tb_vid_linefill;
  localparam int WIDTH = 64, HEIGHT = 8, LINE_BITS = 6, BUF_LOG2 = 2;

  logic clk, reset;
  logic [24:0] addr;
  logic [31:0] din, dout, dma_data;
  logic wen, ren, ready, vid_wen, next_field, dma_run, dma_do_read, dma_ready;
  logic [19:0] vid_addr, curr_vid_addr;
  logic [23:0] vid_data_out, dma_start_addr, dma_end_addr;

  vid_linefill #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .LINE_BITS(LINE_BITS), .BUF_LOG2(BUF_LOG2)) dut (
    .clk(clk), .reset(reset), .addr(addr), .din(din), .wen(wen), .ren(ren), .dout(dout),
    .ready(ready), .vid_addr(vid_addr), .vid_data_out(vid_data_out), .vid_wen(vid_wen),
    .curr_vid_addr(curr_vid_addr), .next_field(next_field), .dma_start_addr(dma_start_addr),
    .dma_end_addr(dma_end_addr), .dma_run(dma_run), .dma_do_read(dma_do_read),
    .dma_ready(dma_ready), .dma_data(dma_data));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0, fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cpu_write(input int wi, input logic [31:0] d, input logic [3:0] page = 4'd0);
    logic [9:0] wv;
    logic ok;
    wv = 10'(wi);
    @(posedge clk); #1;
    addr = {1'b0, page, 8'd0, wv, 2'b00};
    din = d; wen = 1'b1; ok = 1'b0;
    for (int i = 0; i < 5 && !ok; i++) begin
      @(negedge clk); ok = ready;
    end
    chk("wr_ready", {31'd0, ok}, 32'd1);
    @(posedge clk); #1 wen = 1'b0;
  endtask

  task automatic cpu_read(input int wi, output logic [31:0] d);
    logic [9:0] wv;
    logic ok;
    wv = 10'(wi);
    @(posedge clk); #1;
    addr = {1'b0, 4'd0, 8'd0, wv, 2'b00};
    ren = 1'b1; ok = 1'b0; d = '0;
    for (int i = 0; i < 5 && !ok; i++) begin
      @(negedge clk); ok = ready; d = dout;
    end
    chk("rd_ready", {31'd0, ok}, 32'd1);
    @(posedge clk); #1 ren = 1'b0;
  endtask

  task automatic pulse_nf();
    @(posedge clk); #1 next_field = 1'b1;
    @(posedge clk); #1 next_field = 1'b0;
  endtask

  // Waits for the emission of pixel (l, p); flags a timeout as a failure.
  task automatic wait_pix(input int l, input int p, input string name);
    logic [19:0] target;
    logic hit;
    target = {14'(l), 6'(p)};
    hit = 1'b0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      @(negedge clk);
      hit = vid_wen && vid_addr == target;
    end
    chk(name, {31'd0, hit}, 32'd1);
  endtask

  typedef struct packed {
    logic [2:0]        mode;
    logic [31:0]       data;
    logic [5:0]        npix;
    logic [3:0][23:0]  pal;
    logic [63:0]       idx;   // expected palette index of pixel n at [2n+:2]
  } vec_t;

  vec_t vecs[5];

  // Full-field run; optionally parks scanout on slot 2 to check the stall.
  task automatic run_field(input logic [2:0] m, input logic [23:0] fb, input int p, input bit stall);
    int exp_line, cyc, bad, l, px, k, bytes;
    bit done, track, dbl;
`ifdef VID_LINEFILL_LINEDOUBLE_EN
    dbl = m[2];
`else
    dbl = 1'b0;
`endif
    bytes = WIDTH * (1 << m[1:0]) / 8;
    cpu_write(256, {8'd0, fb});
    cpu_write(257, 32'(p));
    cpu_write(258, {29'd0, m});
    curr_vid_addr = stall ? 20'(2 << LINE_BITS) : 20'(3 << LINE_BITS);
    track = !stall;
    dma_data = 32'h5A5A5A5A;
    pulse_nf();
    dma_ready = 1'b1;
    exp_line = 0; done = 1'b0; cyc = 0;
    while (!done && cyc < 4000) begin
      @(negedge clk); cyc++;
      if (vid_wen) begin
        l = int'(vid_addr[19:LINE_BITS]);
        px = int'(vid_addr[LINE_BITS-1:0]);
        if (px == 0) begin
          k = dbl ? l / 2 : l;
          chk($sformatf("line_order_%0d", exp_line), 32'(l), 32'(exp_line));
          chk($sformatf("start_l%0d", l), {8'd0, dma_start_addr}, 32'(24'(fb + k * p)));
          chk($sformatf("end_l%0d", l), {8'd0, dma_end_addr}, 32'(24'(fb + k * p + bytes)));
          if (track) curr_vid_addr = 20'(((l + 3) % 4) << LINE_BITS);
        end
        if (px == WIDTH - 1) begin
          exp_line++;
          if (l == HEIGHT - 1) done = 1'b1;
          if (stall && l == 1) begin
            bad = 0;
            repeat (20) begin
              @(negedge clk); cyc++;
              if (dma_run || vid_wen) bad++;
            end
            chk("slot_stall", 32'(bad), 32'd0);
            curr_vid_addr = 20'(1 << LINE_BITS);
            track = 1'b1;
          end
        end
      end
    end
    chk("field_done", {31'd0, done}, 32'd1);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (dma_run || vid_wen) bad++;
    end
    chk("field_idle", 32'(bad), 32'd0);
    dma_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    int n, nrd, rd_at, cyc;
    vecs[0] = '{3'd2, 32'h00000021, 6'd8,
                {24'h333333, 24'h00FF00, 24'h0000FF, 24'h111111}, 64'h9};
    vecs[1] = '{3'd3, 32'h03020100, 6'd4,
                {24'h000003, 24'h000002, 24'h000001, 24'h000000}, 64'hE4};
    vecs[2] = '{3'd0, 32'h80000001, 6'd32,
                {24'h333333, 24'h222222, 24'h555555, 24'hAAAAAA}, 64'h4000_0000_0000_0001};
    vecs[3] = '{3'd1, 32'h000000E4, 6'd16,
                {24'hC0FFEE, 24'hBEEF00, 24'h00ABCD, 24'h010203}, 64'hE4};
    vecs[4] = '{3'd2, 32'h32103210, 6'd8,
                {24'h0F0F0F, 24'hF0F0F0, 24'h123456, 24'h654321}, 64'hE4E4};

    reset = 1'b1; addr = '0; din = '0; wen = 1'b0; ren = 1'b0;
    curr_vid_addr = '0; next_field = 1'b0; dma_ready = 1'b0; dma_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_dout", dout, 32'd0);
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_vid_wen", {31'd0, vid_wen}, 32'd0);
    chk("rst_vid_addr", {12'd0, vid_addr}, 32'd0);
    chk("rst_vid_data", {8'd0, vid_data_out}, 32'd0);
    chk("rst_dma_run", {31'd0, dma_run}, 32'd0);
    chk("rst_do_read", {31'd0, dma_do_read}, 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    dma_ready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("idle_before_field", {30'd0, dma_run, vid_wen}, 32'd0);
    dma_ready = 1'b0;

    cpu_read(256, rd); chk("rst_fb_addr", rd, 32'h007E0000);
    cpu_read(257, rd); chk("rst_pitch", rd, 32'(WIDTH / 2));
    cpu_read(258, rd); chk("rst_mode", rd, 32'd2);

    cpu_write(256, 32'hAB123456);
    cpu_write(256, 32'h00999999, 4'd1);
    cpu_read(256, rd); chk("fb_addr_page_gate", rd, 32'h00123456);
    cpu_write(257, 32'hFFFFABCD);
    cpu_read(257, rd); chk("pitch_17b", rd, 32'h0001ABCD);
    cpu_write(258, 32'hFFFFFFFE);
    cpu_read(258, rd); chk("mode_rd", rd, 32'd6);
    curr_vid_addr = 20'hABCDE;
    cpu_read(259, rd); chk("scan_pos_rd", rd, 32'h00ABCDE0);
    cpu_read(300, rd); chk("unmapped_rd", rd, 32'd0);
    cpu_read(5, rd);   chk("palette_rd_zero", rd, 32'd0);

    for (int v = 0; v < 5; v++) begin
      for (int e = 0; e < 4; e++) cpu_write(e, {8'd0, vecs[v].pal[e]});
      cpu_write(258, {29'd0, vecs[v].mode});
      curr_vid_addr = 20'(3 << LINE_BITS);
      dma_data = vecs[v].data;
      pulse_nf();
      dma_ready = 1'b1;
      n = 0; nrd = 0; rd_at = -1; cyc = 0;
      while (n < int'(vecs[v].npix) && cyc < 200) begin
        @(negedge clk); cyc++;
        if (vid_wen) begin
          chk($sformatf("v%0d_px%0d", v, n), {8'd0, vid_data_out},
              {8'd0, vecs[v].pal[vecs[v].idx[2*n +: 2]]});
          chk($sformatf("v%0d_addr%0d", v, n), {12'd0, vid_addr}, 32'(n));
          n++;
        end
        if (dma_do_read) begin
          nrd++; rd_at = n;
        end
      end
      chk($sformatf("v%0d_count", v), 32'(n), 32'(vecs[v].npix));
      chk($sformatf("v%0d_pops", v), 32'(nrd), 32'd1);
      chk($sformatf("v%0d_pop_pos", v), 32'(rd_at), 32'(vecs[v].npix - 1));
      @(negedge clk);
      chk($sformatf("v%0d_bubble", v), {31'd0, vid_wen}, 32'd0);
      dma_ready = 1'b0;
    end

    run_field(3'd3, 24'h100000, 256, 1'b1);
    run_field(3'd6, 24'hFFFF00, 128, 1'b0);

    // CPU writes mid-field stay out of the running field; next_field restarts at once.
    cpu_write(256, 32'h00100000);
    cpu_write(257, 32'd256);
    cpu_write(258, 32'd3);
    curr_vid_addr = 20'(3 << LINE_BITS);
    dma_data = 32'h0;
    pulse_nf();
    dma_ready = 1'b1;
    wait_pix(0, 0, "mid_l0_seen");
    cpu_write(256, 32'h00200000);
    cpu_read(256, rd); chk("mid_fb_rd", rd, 32'h00200000);
    wait_pix(1, 0, "mid_l1_seen");
    chk("mid_base_kept", {8'd0, dma_start_addr}, 32'h00100100);
    @(posedge clk); #1 next_field = 1'b1;
    @(posedge clk); #1 next_field = 1'b0;
    @(negedge clk);
    chk("nf_base", {8'd0, dma_start_addr}, 32'h00200000);
    chk("nf_no_emit", {31'd0, vid_wen}, 32'd0);
    @(negedge clk);
    chk("nf_wp_zero", {12'd0, vid_addr}, 32'd0);
    chk("nf_emit", {31'd0, vid_wen}, 32'd1);

    // Reset in the middle of a line abandons it.
    repeat (5) @(negedge clk);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_wen", {31'd0, vid_wen}, 32'd0);
    chk("mid_rst_run", {31'd0, dma_run}, 32'd0);
    chk("mid_rst_addr", {12'd0, vid_addr}, 32'd0);
    repeat (5) @(negedge clk);
    chk("mid_rst_idle", {30'd0, dma_run, vid_wen}, 32'd0);
    dma_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/vid_linefill.md
VID_LINEFILL -- requirements
Module: vid_linefill

Interface
REQ-001 SHALL have parameter WIDTH, default 480: visible pixels per line; SHALL be a multiple of 32.
REQ-002 SHALL have parameter HEIGHT, default 320: lines per field.
REQ-003 SHALL have parameter LINE_BITS, default 9: pixel-index bits in the line-memory address; 2^LINE_BITS >= WIDTH.
REQ-004 SHALL have parameter BUF_LOG2, default 2: log2 of the number of lines in the line-memory ring.
REQ-005 SHALL have clock port clk (input, 1 bit); one clock for all logic.
REQ-006 SHALL have reset port reset (input, 1 bit); synchronous, active-high.
REQ-007 SHALL have the CPU slave ports addr (in, 25), din (in, 32), wen (in, 1), ren (in, 1), dout (out, 32) and ready (out, 1).
REQ-008 SHALL have the line-memory ports vid_addr (out, 20), vid_data_out (out, 24), vid_wen (out, 1), curr_vid_addr (in, 20) = scanout position, and next_field (in, 1) = new-field pulse.
REQ-009 SHALL have the DMA-reader ports dma_start_addr (out, 24), dma_end_addr (out, 24), dma_run (out, 1), dma_do_read (out, 1) = pop, dma_ready (in, 1) = word valid, dma_data (in, 32).

Function
REQ-010 SHALL decode a write only when addr[23:20]==0, using word index w=addr[11:2]: w 0..255 palette[w] <= din[23:0]; 256 fb_addr <= din[23:0]; 257 pitch (bytes) <= din[16:0]; 258 mode <= din[2:0].
REQ-011 SHALL decode mode[1:0] as bpp 0=1, 1=2, 2=4, 3=8; mode[2] = line-double (see REQ-026).
REQ-012 SHALL return on read: w 256..258 = the register value zero-extended; w 259 = {curr_vid_addr, 4'b0}; any other w = 0.
REQ-013 SHALL set ready_write/ready_read one cycle after wen/ren and drive ready = (wen & ready_write) | (ren & ready_read).
REQ-014 SHALL copy fb_addr, pitch and mode into active copies only on next_field; CPU writes mid-field SHALL NOT affect the field being built.
REQ-015 SHALL keep write pointer wp = {line, pix}, where pix is LINE_BITS bits; vid_addr SHALL be wp delayed by one cycle, aligned with vid_data_out and vid_wen.
REQ-016 SHALL treat a line as fillable when line[BUF_LOG2-1:0] != curr_vid_addr[LINE_BITS+BUF_LOG2-1:LINE_BITS]; otherwise it SHALL hold dma_run=0 and vid_wen=0.
REQ-017 SHALL, while fillable, hold dma_run=1, dma_start_addr = current line base, and dma_end_addr = base + WIDTH*bpp/8.
REQ-018 SHALL emit one pixel per cycle only when dma_ready=1: index = dma_data bits [k*bpp +: bpp], k = pix mod (32/bpp), LSB first; vid_data_out <= palette[index] with the index zero-extended to 8 bits; vid_wen <= 1; pix increments.
REQ-019 SHALL pulse dma_do_read for one cycle in the cycle the last pixel of a word is emitted, and SHALL emit nothing in the following cycle (one-cycle bubble for the refreshed dma_data).
REQ-020 SHALL hold vid_wen at 0 in any cycle with no emission.
REQ-021 SHALL, when the pixel at pix==WIDTH-1 is emitted, set pix <= 0 and line <= line+1, advance the base by pitch (per REQ-026), and drop dma_run for one cycle.
REQ-022 SHALL, when line >= HEIGHT, idle with dma_run=0 and vid_wen=0 until next_field.
REQ-023 SHALL, on next_field, set wp <= 0 and base <= new fb_addr, abandoning any partial line; next_field SHALL take priority over emission in the same cycle.
REQ-024 SHALL wrap all address arithmetic modulo 2^24.

Reset
REQ-025 SHALL, on reset, set: dout=0; ready_read=ready_write=0; vid_wen=0; vid_addr=0; vid_data_out=0; dma_run=0; dma_do_read=0; fb_addr=0x7E0000; pitch=WIDTH/2; mode=2 (4 bpp, no doubling); wp line=HEIGHT (idle until the first next_field); palette contents unchanged. Reset mid-line SHALL abandon that line.

Configuration
REQ-026 SHALL gate line doubling with macro VID_LINEFILL_LINEDOUBLE_EN: when defined and active mode[2]=1, the base SHALL advance by pitch only after odd output lines, so each source line is emitted twice; when undefined, mode[2] SHALL be stored and read back but ignored, and the base SHALL advance after every line.

Verification
REQ-027 SHALL cover: palette[1]=0x0000FF, palette[2]=0x00FF00, 4 bpp, dma_data=0x00000021 -> pixel0=0x0000FF, pixel1=0x00FF00, pixels 2..7=palette[0]; dma_do_read pulses once, on pixel7.
REQ-028 SHALL cover: 8 bpp, dma_data=0x03020100, palette[n]=n -> 4 pixels 0,1,2,3 followed by one bubble cycle with vid_wen=0.
REQ-029 SHALL cover: 1 bpp, dma_data=0x80000001 -> 32 pixels, where pixel0 and pixel31 = palette[1] and the rest = palette[0].
REQ-030 SHALL cover: fb_addr=0x100000, pitch=256, full field -> dma_start_addr sequence 0x100000, 0x100100, ...; no fill while the line slot equals the scanout slot; idle after line HEIGHT-1.
REQ-031 SHALL cover: a write to fb_addr mid-field -> no change until next_field; next_field mid-line -> wp=0 on the next cycle.
REQ-032 SHALL cover: with VID_LINEFILL_LINEDOUBLE_EN defined and mode=6 -> dma_start_addr repeats each value for 2 lines; with the macro undefined -> the base advances every line.
